fetch_sequencer: RTL and testbench

Program-counter and fetch-control stage that sits directly upstream of the instruction memory in the single-cycle MIPS-variant processor. It holds the PC, drives the memory's word address, and decodes the control-flow subset of the fetched instruction: `j`, `jal`, `jr`, `beq`, `bgt`, `in` and `halt`. From that decode it computes the next PC and emits `exec_en`, which the datapath uses to gate all architectural writes. It also stalls on the `in` handshake, freezes on `halt`, and counts retired instructions.

---
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and control-flow decode for the
// single-cycle processor. It holds the PC, decodes jumps/branches/in/halt,
// gates architectural writes through exec_en, stalls on the input
// handshake, and stops on halt or on a PC that leaves instruction memory.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_DEPTH = 76
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        in_valid,
    output logic [31:0] read_Address,
    output logic        exec_en,
    output logic        in_ready,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_WAIT_IN,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_J    = 6'b100001;
    localparam logic [5:0] OP_JAL  = 6'b100010;
    localparam logic [5:0] OP_JR   = 6'b100011;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_BGT  = 6'b010100;
    localparam logic [5:0] OP_IN   = 6'b100110;
    localparam logic [5:0] OP_HALT = 6'b100101;

    // The range check is done one bit wider than the PC so that PC+1 from
    // 0xFFFFFFFF is caught as out of range instead of wrapping to zero.
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_DEPTH);

    state_t      state;
    state_t      next_state;
    logic [31:0] next_pc;
    logic [32:0] pc_plus_one;
    logic [32:0] candidate;
    logic        advance;
    logic [5:0]  op;

    assign op          = instruction[31:26];
    assign pc_plus_one = {1'b0, read_Address} + 33'd1;
    assign link_data   = pc_plus_one[31:0];
    assign halted      = (state == S_HALT) || (state == S_FAULT);
    assign fault       = (state == S_FAULT);

    // State and PC register; reset restarts at RESET_PC through one BOOT cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_BOOT;
            read_Address <= RESET_PC;
        end else begin
            state        <= next_state;
            read_Address <= next_pc;
        end
    end

    // Decode the presented instruction into commit strobes, next PC and next state.
    always_comb begin
        next_state = state;
        next_pc    = read_Address;
        exec_en    = 1'b0;
        in_ready   = 1'b0;
        link_we    = 1'b0;
        advance    = 1'b0;
        candidate  = pc_plus_one;
        case (state)
            S_BOOT: begin
                next_state = S_RUN;
            end
            S_RUN: begin
                exec_en = 1'b1;
                advance = 1'b1;
                case (op)
                    OP_J: begin
                        candidate = {7'd0, instruction[25:0]};
                    end
                    OP_JAL: begin
                        candidate = {7'd0, instruction[25:0]};
                        link_we   = 1'b1;
                    end
                    OP_JR: begin
                        candidate = {1'b0, rs_data};
                    end
                    OP_BEQ: begin
                        if (rs_data == rt_data) begin
                            candidate = {17'd0, instruction[15:0]};
                        end
                    end
                    OP_BGT: begin
                        if ($signed(rs_data) > $signed(rt_data)) begin
                            candidate = {17'd0, instruction[15:0]};
                        end
                    end
                    OP_IN: begin
                        in_ready = 1'b1;
                        if (!in_valid) begin
                            exec_en    = 1'b0;
                            advance    = 1'b0;
                            next_state = S_WAIT_IN;
                        end
                    end
                    OP_HALT: begin
                        advance    = 1'b0;
                        next_state = S_HALT;
                    end
                    default: begin
                        candidate = pc_plus_one;
                    end
                endcase
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                exec_en  = in_valid;
                advance  = in_valid;
            end
            default: begin
                next_state = state;
            end
        endcase
        if (advance) begin
            if (candidate >= MEM_LIMIT) begin
                next_state = S_FAULT;
            end else begin
                next_pc    = candidate[31:0];
                next_state = S_RUN;
            end
        end
    end

    // Retired-instruction counter, saturating at all ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= 32'd0;
        end else if (exec_en && (instr_count != 32'hFFFF_FFFF)) begin
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scenario tasks drive the fetch sequencer one cycle at
// a time; each driven cycle pushes its expected outputs to a scoreboard
// queue, and the scenario pops and compares them as the DUT responds.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        in_valid;
    logic [31:0] read_Address;
    logic        exec_en;
    logic        in_ready;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    logic        fault;
    logic [31:0] instr_count;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        inv;
        logic        en;
        logic        rdy;
        logic [31:0] pc;
        logic        hlt;
        logic        flt;
        logic        link;
        logic [31:0] ldat;
    } stim_t;

    stim_t       exp_q[$];
    logic [31:0] exp_count;

    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_sequencer #(
        .RESET_PC (32'd0),
        .MEM_DEPTH(76)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .in_valid    (in_valid),
        .read_Address(read_Address),
        .exec_en     (exec_en),
        .in_ready    (in_ready),
        .link_we     (link_we),
        .link_data   (link_data),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'd0, imm};
    endfunction

    function automatic stim_t mk(input logic [31:0] instr, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic inv, input logic en,
                                 input logic rdy, input logic [31:0] pc,
                                 input logic hlt = 1'b0, input logic flt = 1'b0,
                                 input logic link = 1'b0, input logic [31:0] ldat = 32'd0);
        stim_t s;
        s.instr = instr; s.rs = rs; s.rt = rt; s.inv = inv; s.en = en; s.rdy = rdy;
        s.pc = pc; s.hlt = hlt; s.flt = flt; s.link = link; s.ldat = ldat;
        return s;
    endfunction

    // Drives one cycle of stimulus and records what the DUT must answer.
    task automatic applyStimulus(input stim_t s);
        instruction = s.instr;
        rs_data     = s.rs;
        rt_data     = s.rt;
        in_valid    = s.inv;
        exp_q.push_back(s);
        if (s.en) exp_count = exp_count + 32'd1;
    endtask

    // Reset without checks, leaving the DUT in RUN at RESET_PC.
    task automatic hold_reset();
        reset_n     = 1'b0;
        instruction = NOP;
        in_valid    = 1'b0;
        exp_q.delete();
        exp_count   = 32'd0;
        #3;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        stim_t e;
        reset_n = 1'b1;
        instruction = NOP; rs_data = 32'd0; rt_data = 32'd0; in_valid = 1'b0;
        exp_count = 32'd0;
        #2;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (read_Address !== 32'd0) $display("[TB] FAIL reset_pc: got %0d want 0", read_Address); else passed++;
        if (exec_en !== 1'b0) $display("[TB] FAIL reset_exec_en: got %b want 0", exec_en); else passed++;
        if ({halted, fault, in_ready, link_we} !== 4'b0) $display("[TB] FAIL reset_flags: got %b want 0000", {halted, fault, in_ready, link_we}); else passed++;
        if (instr_count !== 32'd0) $display("[TB] FAIL reset_count: got %0d want 0", instr_count); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks += 2;
        if (exec_en !== 1'b0) $display("[TB] FAIL boot_exec_en: got %b want 0", exec_en); else passed++;
        if (read_Address !== 32'd0) $display("[TB] FAIL boot_pc: got %0d want 0", read_Address); else passed++;
        @(posedge clock);
        #1;
        checks++;
        if (read_Address !== 32'd0) $display("[TB] FAIL run_first_pc: got %0d want 0", read_Address); else passed++;
        s.push_back(mk(NOP, 0, 0, 0, 1, 0, 32'd1));
        s.push_back(mk(NOP, 0, 0, 0, 1, 0, 32'd2));
        s.push_back(mk(NOP, 0, 0, 0, 1, 0, 32'd3));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks += 3;
            if (exec_en !== e.en) $display("[TB] FAIL reset[%0d] exec_en: got %b want %b", i, exec_en, e.en); else passed++;
            if (in_ready !== e.rdy) $display("[TB] FAIL reset[%0d] in_ready: got %b want %b", i, in_ready, e.rdy); else passed++;
            if (link_we !== e.link) $display("[TB] FAIL reset[%0d] link_we: got %b want %b", i, link_we, e.link); else passed++;
            @(posedge clock);
            #1;
            checks += 2;
            if (read_Address !== e.pc) $display("[TB] FAIL reset[%0d] pc: got %0d want %0d", i, read_Address, e.pc); else passed++;
            if ({halted, fault} !== {e.hlt, e.flt}) $display("[TB] FAIL reset[%0d] halted/fault: got %b want %b", i, {halted, fault}, {e.hlt, e.flt}); else passed++;
        end
        checks++;
        if (instr_count !== exp_count) $display("[TB] FAIL reset count: got %0d want %0d", instr_count, exp_count); else passed++;
    endtask

    task automatic test_control_flow();
        stim_t s[$];
        stim_t e;
        s.push_back(mk(enc_j(6'b100001, 26'd7), 0, 0, 0, 1, 0, 32'd7));
        s.push_back(mk(enc_j(6'b100010, 26'd30), 0, 0, 0, 1, 0, 32'd30, 0, 0, 1, 32'd8));
        s.push_back(mk(enc_j(6'b100011, 26'd0), 32'd8, 0, 0, 1, 0, 32'd8));
        s.push_back(mk(enc_i(6'b010000, 16'd40), 32'd5, 32'd5, 0, 1, 0, 32'd40));
        s.push_back(mk(enc_i(6'b010000, 16'd40), 32'd5, 32'd6, 0, 1, 0, 32'd41));
        s.push_back(mk(enc_i(6'b010100, 16'd9), 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 32'd42));
        s.push_back(mk(enc_i(6'b010100, 16'd9), 32'd1, 32'hFFFF_FFFF, 0, 1, 0, 32'd9));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks += 3;
            if (exec_en !== e.en) $display("[TB] FAIL ctrl[%0d] exec_en: got %b want %b", i, exec_en, e.en); else passed++;
            if (in_ready !== e.rdy) $display("[TB] FAIL ctrl[%0d] in_ready: got %b want %b", i, in_ready, e.rdy); else passed++;
            if (link_we !== e.link) $display("[TB] FAIL ctrl[%0d] link_we: got %b want %b", i, link_we, e.link); else passed++;
            if (e.link) begin
                checks++;
                if (link_data !== e.ldat) $display("[TB] FAIL ctrl[%0d] link_data: got %0d want %0d", i, link_data, e.ldat); else passed++;
            end
            @(posedge clock);
            #1;
            checks += 2;
            if (read_Address !== e.pc) $display("[TB] FAIL ctrl[%0d] pc: got %0d want %0d", i, read_Address, e.pc); else passed++;
            if ({halted, fault} !== {e.hlt, e.flt}) $display("[TB] FAIL ctrl[%0d] halted/fault: got %b want %b", i, {halted, fault}, {e.hlt, e.flt}); else passed++;
        end
        checks++;
        if (instr_count !== exp_count) $display("[TB] FAIL ctrl count: got %0d want %0d", instr_count, exp_count); else passed++;
    endtask

    task automatic test_in_stall();
        stim_t s[$];
        stim_t e;
        logic [31:0] in_op;
        in_op = enc_j(6'b100110, 26'd0);
        s.push_back(mk(in_op, 0, 0, 0, 0, 1, 32'd9));
        s.push_back(mk(in_op, 0, 0, 0, 0, 1, 32'd9));
        s.push_back(mk(in_op, 0, 0, 0, 0, 1, 32'd9));
        s.push_back(mk(in_op, 0, 0, 1, 1, 1, 32'd10));
        s.push_back(mk(in_op, 0, 0, 1, 1, 1, 32'd11));
        s.push_back(mk(NOP, 0, 0, 1, 1, 0, 32'd12));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks += 3;
            if (exec_en !== e.en) $display("[TB] FAIL in[%0d] exec_en: got %b want %b", i, exec_en, e.en); else passed++;
            if (in_ready !== e.rdy) $display("[TB] FAIL in[%0d] in_ready: got %b want %b", i, in_ready, e.rdy); else passed++;
            if (link_we !== e.link) $display("[TB] FAIL in[%0d] link_we: got %b want %b", i, link_we, e.link); else passed++;
            @(posedge clock);
            #1;
            checks += 2;
            if (read_Address !== e.pc) $display("[TB] FAIL in[%0d] pc: got %0d want %0d", i, read_Address, e.pc); else passed++;
            if ({halted, fault} !== {e.hlt, e.flt}) $display("[TB] FAIL in[%0d] halted/fault: got %b want %b", i, {halted, fault}, {e.hlt, e.flt}); else passed++;
        end
        checks++;
        if (instr_count !== exp_count) $display("[TB] FAIL in count: got %0d want %0d", instr_count, exp_count); else passed++;
    endtask

    task automatic test_halt();
        stim_t s[$];
        stim_t e;
        s.push_back(mk(enc_j(6'b100001, 26'd70), 0, 0, 0, 1, 0, 32'd70));
        s.push_back(mk(enc_j(6'b100101, 26'd0), 0, 0, 0, 1, 0, 32'd70, 1));
        for (int k = 0; k < 10; k++) begin
            s.push_back(mk((k % 2 == 0) ? enc_j(6'b100001, 26'd5) : enc_j(6'b100110, 26'd0),
                           0, 0, logic'(k % 2), 0, 0, 32'd70, 1));
        end
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks += 3;
            if (exec_en !== e.en) $display("[TB] FAIL halt[%0d] exec_en: got %b want %b", i, exec_en, e.en); else passed++;
            if (in_ready !== e.rdy) $display("[TB] FAIL halt[%0d] in_ready: got %b want %b", i, in_ready, e.rdy); else passed++;
            if (link_we !== e.link) $display("[TB] FAIL halt[%0d] link_we: got %b want %b", i, link_we, e.link); else passed++;
            @(posedge clock);
            #1;
            checks += 2;
            if (read_Address !== e.pc) $display("[TB] FAIL halt[%0d] pc: got %0d want %0d", i, read_Address, e.pc); else passed++;
            if ({halted, fault} !== {e.hlt, e.flt}) $display("[TB] FAIL halt[%0d] halted/fault: got %b want %b", i, {halted, fault}, {e.hlt, e.flt}); else passed++;
        end
        checks++;
        if (instr_count !== exp_count) $display("[TB] FAIL halt count: got %0d want %0d", instr_count, exp_count); else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (read_Address !== 32'd0) $display("[TB] FAIL halt_reset pc: got %0d want 0", read_Address); else passed++;
        if ({halted, fault} !== 2'b00) $display("[TB] FAIL halt_reset halted/fault: got %b want 00", {halted, fault}); else passed++;
        if (instr_count !== 32'd0) $display("[TB] FAIL halt_reset count: got %0d want 0", instr_count); else passed++;
        if ({exec_en, in_ready, link_we} !== 3'b000) $display("[TB] FAIL halt_reset strobes: got %b want 000", {exec_en, in_ready, link_we}); else passed++;
    endtask

    task automatic test_fault();
        stim_t s[$];
        stim_t e;
        for (int sc = 0; sc < 3; sc++) begin
            hold_reset();
            s.delete();
            if (sc == 0) begin
                s.push_back(mk(enc_j(6'b100001, 26'd80), 0, 0, 0, 1, 0, 32'd0, 1, 1));
            end else if (sc == 1) begin
                s.push_back(mk(enc_j(6'b100001, 26'd75), 0, 0, 0, 1, 0, 32'd75));
                s.push_back(mk(NOP, 0, 0, 0, 1, 0, 32'd75, 1, 1));
            end else begin
                s.push_back(mk(enc_j(6'b100011, 26'd0), 32'hFFFF_FFFF, 0, 0, 1, 0, 32'd0, 1, 1));
            end
            for (int k = 0; k < 3; k++) begin
                s.push_back(mk(NOP, 0, 0, 1, 0, 0, s[0].pc, 1, 1));
            end
            for (int i = 0; i < s.size(); i++) begin
                applyStimulus(s[i]);
                @(negedge clock);
                e = exp_q.pop_front();
                checks += 3;
                if (exec_en !== e.en) $display("[TB] FAIL fault%0d[%0d] exec_en: got %b want %b", sc, i, exec_en, e.en); else passed++;
                if (in_ready !== e.rdy) $display("[TB] FAIL fault%0d[%0d] in_ready: got %b want %b", sc, i, in_ready, e.rdy); else passed++;
                if (link_we !== e.link) $display("[TB] FAIL fault%0d[%0d] link_we: got %b want %b", sc, i, link_we, e.link); else passed++;
                @(posedge clock);
                #1;
                checks += 2;
                if (read_Address !== e.pc) $display("[TB] FAIL fault%0d[%0d] pc: got %0d want %0d", sc, i, read_Address, e.pc); else passed++;
                if ({halted, fault} !== {e.hlt, e.flt}) $display("[TB] FAIL fault%0d[%0d] halted/fault: got %b want %b", sc, i, {halted, fault}, {e.hlt, e.flt}); else passed++;
            end
            checks++;
            if (instr_count !== exp_count) $display("[TB] FAIL fault%0d count: got %0d want %0d", sc, instr_count, exp_count); else passed++;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        reset_n     = 1'b1;
        instruction = NOP;
        rs_data     = 32'd0;
        rt_data     = 32'd0;
        in_valid    = 1'b0;
        exp_count   = 32'd0;
        test_reset();
        test_control_flow();
        test_in_stall();
        test_halt();
        test_fault();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
